// File: rtl/e203_itcm_ctrl.sv
// ITCM SRAM controller: round-robin arbitration between IFU fetch and LSU ports,
// single-entry response slots with stall hold, and idle-driven light sleep.
module e203_itcm_ctrl #(
  parameter int DW          = 64,
  parameter int MW          = 8,
  parameter int AW          = 13,
  parameter int IDLE_LS_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [MW-1:0] lsu_cmd_wmask,
  input  logic [DW-1:0] lsu_cmd_wdata,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_ls,
  output logic          ram_ds,
  output logic          ram_sd
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SLEEP, S_WAKE} state_e;

  localparam logic [7:0] LS_LAST = 8'(IDLE_LS_CYC - 1);

  state_e        state_q, state_d;
  logic [7:0]    idle_cnt_q, idle_cnt_d;
  logic          rr_lsu_q, rr_lsu_d;

  logic          ifu_vld_q, ifu_fresh_q;
  logic [DW-1:0] ifu_rdata_q;
  logic          lsu_vld_q, lsu_fresh_q, lsu_rd_q;
  logic [DW-1:0] lsu_rdata_q;

  logic awake, ifu_elig, lsu_elig, grant_ifu, grant_lsu, accept, any_valid;
  logic lsu_wr;

  // A slot can take a new command when empty or when it drains this cycle.
  assign awake     = !rst && (state_q == S_IDLE || state_q == S_ACTIVE);
  assign ifu_elig  = awake && ifu_cmd_valid && (!ifu_vld_q || ifu_rsp_ready);
  assign lsu_elig  = awake && lsu_cmd_valid && (!lsu_vld_q || lsu_rsp_ready);
  assign grant_lsu = lsu_elig && (!ifu_elig || rr_lsu_q);
  assign grant_ifu = ifu_elig && !grant_lsu;
  assign accept    = grant_ifu || grant_lsu;
  assign any_valid = ifu_cmd_valid || lsu_cmd_valid;
  assign lsu_wr    = grant_lsu && !lsu_cmd_read;

  assign ifu_cmd_ready = grant_ifu;
  assign lsu_cmd_ready = grant_lsu;

  assign ram_cs   = accept;
  assign ram_we   = lsu_wr;
  assign ram_addr = grant_lsu ? lsu_cmd_addr : ifu_cmd_addr;
  assign ram_wem  = lsu_wr ? lsu_cmd_wmask : '0;
  assign ram_din  = lsu_wr ? lsu_cmd_wdata : '0;
  assign ram_ls   = (state_q == S_SLEEP);
  assign ram_ds   = 1'b0;
  assign ram_sd   = 1'b0;

  // First response cycle forwards ram_dout; later stall cycles replay the held copy.
  assign ifu_rsp_valid = ifu_vld_q;
  assign ifu_rsp_rdata = ifu_fresh_q ? ram_dout : ifu_rdata_q;
  assign lsu_rsp_valid = lsu_vld_q;
  assign lsu_rsp_rdata = !lsu_rd_q ? '0 : (lsu_fresh_q ? ram_dout : lsu_rdata_q);

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    rr_lsu_d   = rr_lsu_q;
    if (ifu_elig && lsu_elig) rr_lsu_d = grant_ifu;
    case (state_q)
      S_IDLE, S_ACTIVE: begin
        if (accept) begin
          state_d    = S_ACTIVE;
          idle_cnt_d = '0;
        end else if (any_valid) begin
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end else if (state_q == S_IDLE && !ifu_vld_q && !lsu_vld_q) begin
          if (idle_cnt_q == LS_LAST) begin
            state_d    = S_SLEEP;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SLEEP: if (any_valid) state_d = S_WAKE;
      S_WAKE: begin
        state_d    = S_IDLE;
        idle_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      rr_lsu_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      rr_lsu_q   <= rr_lsu_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifu_vld_q   <= 1'b0;
      ifu_fresh_q <= 1'b0;
      ifu_rdata_q <= '0;
    end else begin
      ifu_fresh_q <= grant_ifu;
      if (grant_ifu)          ifu_vld_q <= 1'b1;
      else if (ifu_rsp_ready) ifu_vld_q <= 1'b0;
      if (ifu_fresh_q)        ifu_rdata_q <= ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lsu_vld_q   <= 1'b0;
      lsu_fresh_q <= 1'b0;
      lsu_rd_q    <= 1'b0;
      lsu_rdata_q <= '0;
    end else begin
      lsu_fresh_q <= grant_lsu;
      if (grant_lsu) begin
        lsu_vld_q <= 1'b1;
        lsu_rd_q  <= lsu_cmd_read;
      end else if (lsu_rsp_ready) begin
        lsu_vld_q <= 1'b0;
      end
      if (lsu_fresh_q) lsu_rdata_q <= lsu_rd_q ? ram_dout : '0;
    end
  end

endmodule

// File: doc/e203_itcm_ctrl.md
Name: e203_itcm_ctrl

Overview:
- Arbitrates and sequences the single-port ITCM SRAM macro between two requesters: the IFU fetch port (read only) and the LSU/bus port (read/write with byte mask).
- Sits between the requester command/response channels and the ITCM RAM wrapper (cs/we/addr/wem/din/dout, ls/ds/sd).
- Holds read data when a requester stalls its response.
- Manages light-sleep entry and exit after a programmable idle period.

Parameters:
- DW, 64, RAM data width in bits.
- MW, 8, write-enable mask width (DW/8).
- AW, 13, RAM word address width.
- IDLE_LS_CYC, 16, consecutive idle cycles before ls is asserted (1..255).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- ifu_cmd_valid  in  1  IFU read request.
- ifu_cmd_ready  out  1  IFU request accepted this cycle.
- ifu_cmd_addr  in  AW  IFU word address.
- ifu_rsp_valid  out  1  IFU read data valid.
- ifu_rsp_ready  in  1  IFU consumes response.
- ifu_rsp_rdata  out  DW  IFU read data.
- lsu_cmd_valid  in  1  LSU request.
- lsu_cmd_ready  out  1  LSU request accepted.
- lsu_cmd_read  in  1  1 = read, 0 = write.
- lsu_cmd_addr  in  AW  LSU word address.
- lsu_cmd_wmask  in  MW  byte mask (write only).
- lsu_cmd_wdata  in  DW  write data.
- lsu_rsp_valid  out  1  LSU response valid (read data or write ack).
- lsu_rsp_ready  in  1  LSU consumes response.
- lsu_rsp_rdata  out  DW  LSU read data (0 for writes).
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_wem  out  MW  RAM byte mask.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, valid one cycle after a read cs.
- ram_ls  out  1  RAM light sleep.
- ram_ds  out  1  RAM deep sleep, tied 0.
- ram_sd  out  1  RAM shutdown, tied 0.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; all *_ready=0; all rsp_valid=0; ram_cs=0; ram_we=0; ram_ls=0; rdata=0; idle counter=0; round-robin pointer favours LSU.
- States:
  - IDLE: RAM awake, no request.
  - ACTIVE: a RAM access was issued this cycle.
  - SLEEP: ram_ls=1.
  - WAKE: one cycle with ram_ls=0 and no cs.
- Accept condition:
  - A command is accepted (cmd_valid & cmd_ready) only in IDLE or ACTIVE.
  - The response slot must be empty, or being drained this cycle (rsp_valid & rsp_ready).
  - At most one accept per cycle.
  - ram_cs, addr, we, wem and din are driven combinationally in the accept cycle.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the round-robin pointer selects the winner and then toggles to the loser.
  - The non-winner sees cmd_ready=0.
- Read latency: response valid the cycle after accept. rdata is captured from ram_dout into that requester's holding register and held stable until rsp_ready.
- Write: ram_we=1, ram_wem=lsu_cmd_wmask. lsu_rsp_valid is asserted next cycle with rdata=0.
- Per-requester response slot (1 entry each):
  - rsp_valid stays high until rsp_ready.
  - Data must not change while stalled.
  - A new accept for that requester is allowed in the same cycle the old response drains (back-to-back throughput: 1 access/cycle).
- Idle counter:
  - Increments each cycle in IDLE with no cmd_valid and both rsp slots empty.
  - Cleared by any cmd_valid or any accept.
  - On reaching IDLE_LS_CYC: go to SLEEP, ram_ls=1.
- SLEEP: any cmd_valid -> WAKE (ls drops to 0, no ready). WAKE -> IDLE the next cycle, where the request is accepted. Wake-up penalty is 2 cycles.
- Address and data are registered only in the response slot. The RAM sees combinational command signals; no RAM access is ever issued while ram_ls=1.
- Reset mid-operation: outstanding responses are discarded and the response slots cleared; there are no partial writes beyond the single cs cycle.
- rsp_ready with rsp_valid=0 is ignored. cmd fields are don't-care when cmd_valid=0.

Test Plan:
- IFU read of addr 0x010 after preloading 0xDEADBEEF_01234567, rsp_ready=1: ram_cs at T0, ifu_rsp_valid at T1 with that data; a second read is accepted at T1.
- Both requesters valid for 4 cycles after reset: grants alternate LSU, IFU, LSU, IFU; the non-winner sees cmd_ready=0 each cycle.
- LSU write addr 0x3, wmask 0x0F, wdata 0x11223344_55667788 over initial 0xFFFF..., then read: ack at T1 with rdata 0; readback 0xFFFFFFFF_55667788.
- IFU read with ifu_rsp_ready=0 for 3 cycles while ram_dout changes: rdata stays stable and ifu_cmd_ready=0 for further IFU requests; LSU requests are still served.
- No requests for 16 cycles (IDLE_LS_CYC=16): ram_ls=1 from cycle 16. An IFU request then sees ls=0 at T+1 (WAKE), is accepted at T+2, and returns rsp at T+3.
- Assert rst during a stalled read response: rsp_valid=0, ram_cs=0 and ram_ls=0 immediately (asynchronously); after deassert the block is back in IDLE with the pointer favouring LSU.
